// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, port ids and command builder for the data-memory controller
package dmem_pkg;
    localparam int WORD_W    = 32;
    localparam int PORT_PIPE = 0;
    localparam int PORT_LOAD = 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    typedef struct packed {
        logic              write;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic              misalign;
    } cmd_t;

    function automatic cmd_t make_cmd(input logic write, input logic [WORD_W-1:0] addr,
                                      input logic [WORD_W-1:0] wdata);
        return '{write: write, addr: addr, wdata: wdata, misalign: |addr[1:0]};
    endfunction
endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: both requester ports plus the RAM command bus of the controller
interface dmem_ctrl_if #(parameter int DMEM_POWER = 18);
    import dmem_pkg::*;
    logic                  p0Valid, p0Write, p0Ready;
    logic [WORD_W-1:0]     p0Addr, p0WData, p0RData;
    logic                  p1Valid, p1Write, p1Ready;
    logic [WORD_W-1:0]     p1Addr, p1WData, p1RData;
    logic                  alignErr, stallM;
    logic                  memEn, memWe;
    logic [DMEM_POWER-1:0] memAddr;
    logic [WORD_W-1:0]     memWData, memRData;

    modport slave (
        input  p0Valid, p0Write, p0Addr, p0WData,
        input  p1Valid, p1Write, p1Addr, p1WData,
        input  memRData,
        output p0Ready, p0RData, p1Ready, p1RData,
        output alignErr, stallM, memEn, memWe, memAddr, memWData
    );

    modport master (
        output p0Valid, p0Write, p0Addr, p0WData,
        output p1Valid, p1Write, p1Addr, p1WData,
        output memRData,
        input  p0Ready, p0RData, p1Ready, p1RData,
        input  alignErr, stallM, memEn, memWe, memAddr, memWData
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with a one-hot grant
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic last_q;

    // a tie goes to the requester that did not win last time
    always_comb gnt_o = (&req_i) ? (last_q ? 2'b01 : 2'b10) : req_i;

    // remember the winner only when the grant is actually taken
    always_ff @(posedge clk or posedge rst)
        if (rst) last_q <= 1'b1;
        else if (en_i && |req_i) last_q <= gnt_o[1];
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data-memory controller sharing one RAM between pipeline and loader ports
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DMEM_POWER = 18,
    parameter int LATENCY    = 1
) (
    input logic        clk,
    input logic        reset,
    dmem_ctrl_if.slave bus
);
    localparam int            CW       = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    cmd_t              cmd_q, cmd_d;
    logic              port_q, port_d;
    logic [WORD_W-1:0] rdata0_q, rdata1_q;
    logic [1:0]        gnt;
    logic              arb_en, mem_en, done, capture, unused_addr;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (reset),
        .en_i  (arb_en),
        .req_i ({bus.p1Valid, bus.p0Valid}),
        .gnt_o (gnt)
    );

    // state register with the transaction context it owns
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            port_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            port_q  <= port_d;
        end

    // next state: grant and latch in IDLE, count down ACCESS, single DONE cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        port_d  = port_q;
        arb_en  = 1'b0;
        case (state_q)
            IDLE: if (|gnt) begin
                arb_en  = 1'b1;
                port_d  = gnt[PORT_LOAD];
                cmd_d   = gnt[PORT_LOAD] ? make_cmd(bus.p1Write, bus.p1Addr, bus.p1WData)
                                         : make_cmd(bus.p0Write, bus.p0Addr, bus.p0WData);
                cnt_d   = CNT_INIT;
                state_d = ACCESS;
            end
            ACCESS: begin
                cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
                state_d = (cnt_q == '0) ? DONE : ACCESS;
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs: strobe on the first ACCESS cycle, hold address/data, pulse ready in DONE
    always_comb begin
        mem_en       = (state_q == ACCESS) && (cnt_q == CNT_INIT);
        done         = (state_q == DONE);
        capture      = (state_q == ACCESS) && (cnt_q == '0) && !cmd_q.write;
        bus.memEn    = mem_en;
        bus.memWe    = mem_en & cmd_q.write;
        bus.memAddr  = (state_q == ACCESS) ? cmd_q.addr[DMEM_POWER+1:2] : '0;
        bus.memWData = (state_q == ACCESS) ? cmd_q.wdata : '0;
        bus.p0Ready  = done & ~port_q;
        bus.p1Ready  = done & port_q;
        bus.alignErr = done & cmd_q.misalign;
        bus.stallM   = bus.p0Valid & ~(done & ~port_q) & ~reset;
        bus.p0RData  = rdata0_q;
        bus.p1RData  = rdata1_q;
        unused_addr  = ^{cmd_q.addr[WORD_W-1:DMEM_POWER+2], cmd_q.addr[1:0]};
    end

    // load data lands in the granted port's register at the end of the last ACCESS cycle
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (capture && !port_q) rdata0_q <= bus.memRData;
            if (capture && port_q)  rdata1_q <= bus.memRData;
        end
endmodule
